sram_hs_model: RTL and testbench
================================

# sram_hs_model

Parametrised single-port SRAM behavioural model with a valid/ready request channel, a valid/ready response channel, byte-enable writes, full-width read data and programmable access latency. It replaces the fixed 16×8-bit `mem_resp` memory model. It sits behind the memory interface (MIF) in unit-test benches and lets MIF stall and back-pressure logic be exercised at realistic latencies.

## Interface
- DATA_WIDTH, 16, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10, address width; depth = 2**ADDR_WIDTH words.
- LATENCY, 2, cycles from request accept to response valid; must be >= 1.
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  model can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_be  in  DATA_WIDTH/8  byte enables; bit i covers bits [8i+7:8i].
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_we  out  1  1 = write acknowledge, 0 = read data.
- resp_rdata  out  DATA_WIDTH  read data; 0 for writes.

## Operation
- One outstanding transaction. FSM states:
  - **IDLE**: req_ready=1. On req_valid&req_ready: LATENCY==1 → RESP, else → WAIT with cnt=LATENCY-1.
  - **WAIT**: cnt decrements each cycle; cnt==1 → RESP.
  - **RESP**: resp_valid=1; resp_we/resp_rdata held stable. On resp_ready → IDLE.
- Memory access is committed in the accept cycle:
  - Write: bytes with req_be[i]=1 are updated; other bytes are unchanged.
  - Read: mem[req_addr] is captured into the response register.
- req_be all zero: write leaves memory unchanged, but a write acknowledge is still returned.
- Read immediately after a write to the same address returns the new data.
- Requests presented while req_ready=0 are ignored. req_* fields are sampled only at accept.
- Counter width is $clog2(LATENCY+1).

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_we=0, resp_rdata=0, state IDLE, cnt=0.
- Request accepted at edge T → resp_valid first high in cycle T+LATENCY.
- resp_valid stays high until the edge where resp_ready=1. req_ready rises in the following cycle.
- Minimum request-to-request spacing is LATENCY+1 cycles.
- resp_ready high before resp_valid has no effect.
- Reset asserted mid-transaction:
  - The pending response is dropped and all outputs return to reset values.
  - A write already accepted remains in memory, unless the init option below overwrites it.

## Configuration
- SRAM_HS_INIT_ON_RESET_EN defined: while reset_n=0, every word i is loaded with i, truncated to DATA_WIDTH.
- Undefined: memory contents are untouched by reset. Unwritten words read X in simulation.

## Test plan
- Init defined, LATENCY=2: reset, then read addr 0x005 → resp_valid exactly 2 cycles after accept, resp_rdata=0x0005, resp_we=0.
- Write 0xBEEF to 0x010 with be=2'b11, then read 0x010 → write ack (resp_we=1, rdata=0), then rdata=0xBEEF.
- Partial write: 0x1234 at 0x020, then 0xAB00 with be=2'b10 → read 0x020 returns 0xAB34.
- Back-pressure: hold resp_ready=0 for 5 cycles after resp_valid → resp_valid and resp_rdata stable, req_ready=0 throughout; resp_ready=1 → req_ready=1 next cycle.
- LATENCY=1 build: read accepted at T → resp_valid at T+1. LATENCY=4 build: resp_valid at T+4.
- Reset in WAIT after write 0x5A5A to 0x030, init undefined → outputs at reset values next cycle; later read of 0x030 returns 0x5A5A.

Source files
------------

// File: rtl/sram_hs_model.sv
// Single-port SRAM model with valid/ready request and response channels and programmable latency.
// Define SRAM_HS_INIT_ON_RESET_EN to load word i with value i while reset_n is low.
module sram_hs_model #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned LATENCY    = 2
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_be,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic                    resp_we,
   output logic [DATA_WIDTH-1:0]   resp_rdata
);

   localparam int unsigned BE_W  = DATA_WIDTH / 8;
   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam int unsigned CNT_W = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   req_ready_d, resp_valid_d, resp_we_d;
   logic [DATA_WIDTH-1:0]  resp_rdata_d;
   logic                   accept;

   logic [DATA_WIDTH-1:0]  mem [DEPTH];

   // Next-state and next-output logic; memory read is captured at accept.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      resp_we_d    = resp_we;
      resp_rdata_d = resp_rdata;
      accept       = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               accept       = 1'b1;
               resp_we_d    = req_we;
               resp_rdata_d = req_we ? '0 : mem[req_addr];
               if (LATENCY == 1) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_W'(LATENCY - 1);
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = RESP;
         end
         RESP: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      req_ready_d  = (state_d == IDLE);
      resp_valid_d = (state_d == RESP);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_we    <= 1'b0;
         resp_rdata <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         req_ready  <= req_ready_d;
         resp_valid <= resp_valid_d;
         resp_we    <= resp_we_d;
         resp_rdata <= resp_rdata_d;
      end
   end

   // Storage: byte-enabled writes committed in the accept cycle.
   always_ff @(posedge clk) begin
`ifdef SRAM_HS_INIT_ON_RESET_EN
      if (!reset_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= DATA_WIDTH'(i);
      end else
`endif
      if (reset_n && accept && req_we) begin
         for (int unsigned b = 0; b < BE_W; b++) begin
            if (req_be[b]) mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_sram_hs_model.sv
// Directed bench for sram_hs_model: LATENCY=2 main instance plus LATENCY=1 and LATENCY=4 instances.
module tb_sram_hs_model;

   localparam int unsigned DW = 16;
   localparam int unsigned AW = 10;
   localparam int unsigned BW = DW / 8;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic [BW-1:0] req_be = '0;
   logic          resp_ready = 1'b0;
   logic          req_ready, resp_valid, resp_we;
   logic [DW-1:0] resp_rdata;

   logic          aux_valid = 1'b0;
   logic          aux_resp_ready = 1'b1;
   logic          a1_req_ready, a1_resp_valid, a1_resp_we;
   logic [DW-1:0] a1_resp_rdata;
   logic          a4_req_ready, a4_resp_valid, a4_resp_we;
   logic [DW-1:0] a4_resp_rdata;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sram_hs_model #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_we(resp_we), .resp_rdata(resp_rdata)
   );

   sram_hs_model #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(1)) dut_l1 (
      .clk(clk), .reset_n(reset_n),
      .req_valid(aux_valid), .req_ready(a1_req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(a1_resp_valid), .resp_ready(aux_resp_ready),
      .resp_we(a1_resp_we), .resp_rdata(a1_resp_rdata)
   );

   sram_hs_model #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(4)) dut_l4 (
      .clk(clk), .reset_n(reset_n),
      .req_valid(aux_valid), .req_ready(a4_req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(a4_resp_valid), .resp_ready(aux_resp_ready),
      .resp_we(a4_resp_we), .resp_rdata(a4_resp_rdata)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one request on the main instance; lat counts cycles with the accept cycle as 1.
   task automatic send(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input logic [BW-1:0] be, output int lat);
      @(negedge clk);
      check("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; req_we = ~we; req_wdata = '1; req_be = '1;
      lat = 1;
      while (!resp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (!resp_valid) check("resp_timeout", 32'd0, 32'd1);
   endtask

   task automatic finish_resp();
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
      check("resp_valid_drop", 32'(resp_valid), 32'd0);
      check("req_ready_back", 32'(req_ready), 32'd1);
   endtask

   task automatic txn(input string tag, input logic we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input logic [BW-1:0] be, input logic [DW-1:0] exp_rdata);
      int lat;
      send(we, addr, wdata, be, lat);
      check({tag, "_lat"}, 32'(lat), 32'd2);
      check({tag, "_we"}, 32'(resp_we), 32'(we));
      check({tag, "_rdata"}, 32'(resp_rdata), 32'(exp_rdata));
      finish_resp();
   endtask

   // Same request on the LATENCY=1 and LATENCY=4 instances; responses auto-consumed.
   task automatic aux_txn(input string tag, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata);
      int l1, l4;
      @(negedge clk);
      check({tag, "_l1_ready"}, 32'(a1_req_ready), 32'd1);
      check({tag, "_l4_ready"}, 32'(a4_req_ready), 32'd1);
      aux_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = '1;
      @(posedge clk);
      @(negedge clk);
      aux_valid = 1'b0;
      l1 = 0; l4 = 0;
      for (int n = 1; n <= 8; n++) begin
         if (a1_resp_valid && l1 == 0) begin
            l1 = n;
            check({tag, "_l1_we"}, 32'(a1_resp_we), 32'(we));
            check({tag, "_l1_rdata"}, 32'(a1_resp_rdata), 32'(exp_rdata));
         end
         if (a4_resp_valid && l4 == 0) begin
            l4 = n;
            check({tag, "_l4_we"}, 32'(a4_resp_we), 32'(we));
            check({tag, "_l4_rdata"}, 32'(a4_resp_rdata), 32'(exp_rdata));
         end
         @(negedge clk);
      end
      check({tag, "_l1_lat"}, 32'(l1), 32'd1);
      check({tag, "_l4_lat"}, 32'(l4), 32'd4);
   endtask

   initial begin
      int lat;
      // Reset values
      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_we", 32'(resp_we), 32'd0);
      check("rst_resp_rdata", 32'(resp_rdata), 32'd0);
      reset_n = 1'b1;

`ifdef SRAM_HS_INIT_ON_RESET_EN
      txn("init_rd5", 1'b0, 10'h005, 16'h0000, 2'b00, 16'h0005);
`endif

      // Full write, then read back
      txn("wr_beef", 1'b1, 10'h010, 16'hBEEF, 2'b11, 16'h0000);
      txn("rd_beef", 1'b0, 10'h010, 16'h0000, 2'b00, 16'hBEEF);

      // Partial write merges with existing bytes; zero enables leave data intact
      txn("wr_1234", 1'b1, 10'h020, 16'h1234, 2'b11, 16'h0000);
      txn("wr_ab00", 1'b1, 10'h020, 16'hAB00, 2'b10, 16'h0000);
      txn("rd_ab34", 1'b0, 10'h020, 16'h0000, 2'b00, 16'hAB34);
      txn("wr_be0", 1'b1, 10'h020, 16'hFFFF, 2'b00, 16'h0000);
      txn("rd_be0", 1'b0, 10'h020, 16'h0000, 2'b00, 16'hAB34);

      // Back-pressure: response held, concurrent requests ignored
      send(1'b0, 10'h010, 16'h0000, 2'b00, lat);
      check("bp_lat", 32'(lat), 32'd2);
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", 32'(resp_valid), 32'd1);
         check("bp_rdata", 32'(resp_rdata), 32'hBEEF);
         check("bp_req_ready", 32'(req_ready), 32'd0);
         req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h010; req_wdata = 16'h0000; req_be = 2'b11;
         @(negedge clk);
      end
      req_valid = 1'b0;
      finish_resp();
      txn("rd_after_bp", 1'b0, 10'h010, 16'h0000, 2'b00, 16'hBEEF);

      // resp_ready already high before resp_valid
      resp_ready = 1'b1;
      send(1'b0, 10'h020, 16'h0000, 2'b00, lat);
      check("early_rdy_lat", 32'(lat), 32'd2);
      check("early_rdy_rdata", 32'(resp_rdata), 32'hAB34);
      finish_resp();

      // Reset while waiting on an accepted write
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h030; req_wdata = 16'h5A5A; req_be = 2'b11;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("wait_resp_valid", 32'(resp_valid), 32'd0);
      check("wait_req_ready", 32'(req_ready), 32'd0);
      reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midrst_req_ready", 32'(req_ready), 32'd1);
      check("midrst_resp_valid", 32'(resp_valid), 32'd0);
      check("midrst_resp_we", 32'(resp_we), 32'd0);
      check("midrst_resp_rdata", 32'(resp_rdata), 32'd0);
      reset_n = 1'b1;
`ifdef SRAM_HS_INIT_ON_RESET_EN
      txn("rd_after_rst", 1'b0, 10'h030, 16'h0000, 2'b00, 16'h0030);
`else
      txn("rd_after_rst", 1'b0, 10'h030, 16'h0000, 2'b00, 16'h5A5A);
`endif

      // Latency 1 and 4 instances
      aux_txn("aux_wr", 1'b1, 10'h007, 16'hC3A5, 16'h0000);
      aux_txn("aux_rd", 1'b0, 10'h007, 16'h0000, 16'hC3A5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
